// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and configuration checks for the FIFO write-port arbiter.
// Build option FIFO_ARB_FIXED_PRI_EN switches the picker to fixed priority.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_WRITE = 1'b1
  } arb_state_t;

  localparam int MIN_NREQ = 2;
  localparam int MAX_NREQ = 8;

  function automatic bit nreq_legal(input int nreq, input int idxw);
    return (nreq >= MIN_NREQ) && (nreq <= MAX_NREQ) && ((1 << idxw) >= nreq);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational winner picker: round-robin from ptr+1, or lowest index
// when FIFO_ARB_FIXED_PRI_EN is defined.
module rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] winner,
  output logic            any_req
);

`ifdef FIFO_ARB_FIXED_PRI_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    winner  = '0;
    any_req = |req;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[i]) winner = IDXW'(i);
  end
`else
  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    winner  = '0;
    any_req = |req;
    for (int k = NREQ; k >= 1; k--)
      if (req[(int'(ptr) + k) % NREQ]) winner = IDXW'((int'(ptr) + k) % NREQ);
  end
`endif

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one FIFO write port among NREQ producers; one word per two cycles.
// Define FIFO_ARB_FIXED_PRI_EN for fixed (lowest-index) priority.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDXW  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  input  logic                  fifo_full,
  output logic [WIDTH-1:0]      d_in,
  output logic                  d_in_strobe,
  output logic [IDXW-1:0]       grant_idx,
  output logic                  busy
);

  generate
    if (!nreq_legal(NREQ, IDXW)) begin : g_bad_cfg
      $error("fifo_wr_arbiter: illegal NREQ/IDXW combination");
    end
  endgenerate

  arb_state_t      state, state_nxt;
  logic [IDXW-1:0] ptr, winner;
  logic            any_req, start;
  logic [WIDTH-1:0] win_data;

  rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  // fifo_full only matters when a decision is being made, i.e. in IDLE.
  assign start = (state == ARB_IDLE) && any_req && !fifo_full;

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (start) state_nxt = ARB_WRITE;
      ARB_WRITE: state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= ARB_IDLE;
    else          state <= state_nxt;

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (IDXW'(i) == winner) win_data = req_data[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack       <= '0;
      d_in      <= '0;
      grant_idx <= '0;
      ptr       <= IDXW'(NREQ - 1);
    end else if (start) begin
      ack         <= '0;
      ack[winner] <= 1'b1;
      d_in        <= win_data;
      grant_idx   <= winner;
`ifndef FIFO_ARB_FIXED_PRI_EN
      ptr         <= winner;
`endif
    end else begin
      ack <= '0;
    end
  end

  assign d_in_strobe = (state == ARB_WRITE);
  assign busy        = (state == ARB_WRITE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a behavioural FIFO on its write port.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack;
  logic        fifo_full;
  logic [7:0]  d_in;
  logic        d_in_strobe;
  logic [1:0]  grant_idx;
  logic        busy;

  int chk = 0;
  int err = 0;

  int fdepth = 4;
  int fcnt = 0;
  int cyc = 0;
  int fall_cyc = -1;
  bit drain = 1'b0;
  bit pop_req = 1'b0;
  bit force_full = 1'b0;

  logic [7:0] mem[$];
  logic [7:0] wdata[$];
  logic [3:0] wack[$];
  logic [1:0] wgnt[$];
  int         wcyc[$];

  assign fifo_full = force_full || (fcnt >= fdepth);

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.WIDTH(8), .NREQ(4), .IDXW(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .fifo_full   (fifo_full),
    .d_in        (d_in),
    .d_in_strobe (d_in_strobe),
    .grant_idx   (grant_idx),
    .busy        (busy)
  );

  // FIFO model: captures d_in on strobe edges and logs each write.
  always @(posedge clk) begin
    int push;
    int pop;
    push = d_in_strobe ? 1 : 0;
    pop  = ((pop_req || drain) && fcnt > 0) ? 1 : 0;
    if (!reset_n) begin
      fcnt <= 0;
      mem.delete();
      wdata.delete();
      wack.delete();
      wgnt.delete();
      wcyc.delete();
    end else begin
      if (push == 1) begin
        mem.push_back(d_in);
        wdata.push_back(d_in);
        wack.push_back(ack);
        wgnt.push_back(grant_idx);
        wcyc.push_back(cyc);
      end
      if (pop == 1) begin
        void'(mem.pop_front());
        if (fcnt == 1 && push == 0) fall_cyc = cyc;
      end
      fcnt <= fcnt + push - pop;
    end
    cyc <= cyc + 1;
  end

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    req_data = '0;
    drain = 1'b0;
    pop_req = 1'b0;
    force_full = 1'b0;
    fdepth = 4;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    bit found;
    reset_n = 1'b0;
    req = 4'hF;
    req_data = 32'h13121110;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk++; if (ack !== 4'b0000) begin err++; $display("FAIL reset_ack: got %b exp 0000", ack); end
    chk++; if (d_in_strobe !== 1'b0) begin err++; $display("FAIL reset_strobe: got %b exp 0", d_in_strobe); end
    chk++; if (grant_idx !== 2'd0) begin err++; $display("FAIL reset_grant: got %0d exp 0", grant_idx); end
    chk++; if (busy !== 1'b0) begin err++; $display("FAIL reset_busy: got %b exp 0", busy); end
    chk++; if (d_in !== 8'h00) begin err++; $display("FAIL reset_d_in: got %h exp 00", d_in); end
    reset_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (ack != 4'b0000) found = 1'b1;
    end
    chk++;
    if (!found) begin
      err++; $display("FAIL reset_first_ack: got timeout exp ack");
    end else begin
      if (ack !== 4'b0001) begin err++; $display("FAIL reset_first_ack: got %b exp 0001", ack); end
      chk++; if (d_in !== 8'h10) begin err++; $display("FAIL reset_first_data: got %h exp 10", d_in); end
    end
    req = '0;
  endtask

  task automatic test_single();
    bit found;
    do_reset();
    @(negedge clk);
    req = 4'b0100;
    req_data = 32'h00550000;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (ack != 4'b0000) found = 1'b1;
    end
    chk++;
    if (!found) begin
      err++; $display("FAIL single_ack: got timeout exp 0100");
    end else begin
      if (ack !== 4'b0100) begin err++; $display("FAIL single_ack: got %b exp 0100", ack); end
      chk++; if (d_in !== 8'h55) begin err++; $display("FAIL single_data: got %h exp 55", d_in); end
      chk++; if (d_in_strobe !== 1'b1) begin err++; $display("FAIL single_strobe: got %b exp 1", d_in_strobe); end
      chk++; if (grant_idx !== 2'd2) begin err++; $display("FAIL single_grant: got %0d exp 2", grant_idx); end
    end
    req = '0;
    @(negedge clk);
    chk++; if (ack !== 4'b0000 || d_in_strobe !== 1'b0) begin
      err++; $display("FAIL single_pulse: got ack=%b strobe=%b exp 0000/0", ack, d_in_strobe);
    end
    repeat (4) @(negedge clk);
    chk++; if (wdata.size() != 1) begin err++; $display("FAIL single_count: got %0d exp 1", wdata.size()); end
    chk++; if (fcnt != 1 || mem.size() == 0 || mem[0] !== 8'h55) begin
      err++; $display("FAIL single_fifo_q: got count=%0d exp count=1 q=55", fcnt);
    end
  endtask

  task automatic test_round_robin();
    int         exp_g[6];
    logic [7:0] exp_d[6];
`ifdef FIFO_ARB_FIXED_PRI_EN
    exp_g = '{0, 0, 0, 0, 0, 0};
    exp_d = '{8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24};
`else
    exp_g = '{0, 1, 2, 3, 0, 1};
    exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
`endif
    do_reset();
    drain = 1'b1;
    @(negedge clk);
    req = 4'hF;
    req_data = 32'h13121110;
    for (int c = 0; c < 40 && wdata.size() < 6; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if (ack[i]) req_data[i*8 +: 8] = req_data[i*8 +: 8] + 8'h04;
    end
    req = '0;
    chk++;
    if (wdata.size() < 6) begin
      err++; $display("FAIL rr_count: got %0d exp 6", wdata.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        chk++; if (int'(wgnt[k]) != exp_g[k]) begin
          err++; $display("FAIL rr_grant[%0d]: got %0d exp %0d", k, wgnt[k], exp_g[k]);
        end
        chk++; if (wack[k] !== 4'(1 << exp_g[k])) begin
          err++; $display("FAIL rr_ack[%0d]: got %b exp %b", k, wack[k], 4'(1 << exp_g[k]));
        end
        chk++; if (wdata[k] !== exp_d[k]) begin
          err++; $display("FAIL rr_data[%0d]: got %h exp %h", k, wdata[k], exp_d[k]);
        end
        if (k > 0) begin
          chk++; if (wcyc[k] - wcyc[k-1] != 2) begin
            err++; $display("FAIL rr_spacing[%0d]: got %0d exp 2", k, wcyc[k] - wcyc[k-1]);
          end
        end
      end
    end
  endtask

  task automatic test_full_backpressure();
    do_reset();
    fdepth = 1;
    @(negedge clk);
    req = 4'b0010;
    req_data = 32'h0000AA00;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ack[1]) req_data[15:8] = 8'hBB;
    end
    chk++; if (wdata.size() != 1) begin err++; $display("FAIL full_count: got %0d exp 1", wdata.size()); end
    chk++; if (wdata.size() > 0 && wdata[0] !== 8'hAA) begin
      err++; $display("FAIL full_first: got %h exp AA", wdata[0]);
    end
    chk++; if (fifo_full !== 1'b1) begin err++; $display("FAIL full_flag: got %b exp 1", fifo_full); end
    chk++; if (d_in_strobe !== 1'b0 || ack !== 4'b0000) begin
      err++; $display("FAIL full_hold: got strobe=%b ack=%b exp 0/0000", d_in_strobe, ack);
    end
    pop_req = 1'b1;
    @(negedge clk);
    pop_req = 1'b0;
    for (int c = 0; c < 10 && wdata.size() < 2; c++) begin
      @(negedge clk);
      if (ack[1]) req = '0;
    end
    req = '0;
    chk++;
    if (wdata.size() < 2) begin
      err++; $display("FAIL full_second: got %0d writes exp 2", wdata.size());
    end else begin
      if (wdata[1] !== 8'hBB) begin err++; $display("FAIL full_second: got %h exp BB", wdata[1]); end
      chk++; if (wcyc[1] != fall_cyc + 2) begin
        err++; $display("FAIL full_latency: got %0d exp %0d", wcyc[1] - fall_cyc, 2);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    bit found;
    do_reset();
    drain = 1'b1;
    @(negedge clk);
    req = 4'b0100;
    req_data = 32'h00770000;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (d_in_strobe) found = 1'b1;
    end
    chk++;
    if (!found) begin
      err++; $display("FAIL midrst_write: got timeout exp strobe");
    end else begin
      reset_n = 1'b0;
      #1;
      if (d_in_strobe !== 1'b0) begin err++; $display("FAIL midrst_strobe: got %b exp 0", d_in_strobe); end
      chk++; if (ack !== 4'b0000) begin err++; $display("FAIL midrst_ack: got %b exp 0000", ack); end
      chk++; if (busy !== 1'b0) begin err++; $display("FAIL midrst_busy: got %b exp 0", busy); end
    end
    req = 4'hF;
    req_data = 32'h13121110;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (ack != 4'b0000) found = 1'b1;
    end
    req = '0;
    chk++;
    if (!found) begin
      err++; $display("FAIL midrst_regrant: got timeout exp 0001");
    end else begin
      if (ack !== 4'b0001) begin err++; $display("FAIL midrst_regrant: got %b exp 0001", ack); end
      chk++; if (grant_idx !== 2'd0) begin err++; $display("FAIL midrst_grant: got %0d exp 0", grant_idx); end
    end
  endtask

  task automatic test_abandoned();
    bit seen;
    do_reset();
    force_full = 1'b1;
    @(negedge clk);
    req = 4'b1000;
    req_data = 32'hEE000000;
    @(negedge clk);
    chk++; if (busy !== 1'b0) begin err++; $display("FAIL aband_busy: got %b exp 0", busy); end
    req = '0;
    @(negedge clk);
    force_full = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ack != 4'b0000 || d_in_strobe) seen = 1'b1;
    end
    chk++; if (seen) begin err++; $display("FAIL aband_ack: got activity exp none"); end
    chk++; if (wdata.size() != 0) begin err++; $display("FAIL aband_count: got %0d exp 0", wdata.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_backpressure();
    test_reset_mid_write();
    test_abandoned();
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
